// File: rtl/cm0ik_ahb_dec_mux.sv
// cm0ik_ahb_dec_mux: AHB-Lite address decoder and slave-to-master response mux.
// It decodes three slaves plus a default slave, and has an optional hang timeout.
//
// Ports
//   HCLK, HRESETn                  clock, synchronous active-low reset
//   HADDR, HTRANS                  master address-phase inputs
//   HSEL[2:0], HSELDEF             combinational one-hot slave selects
//   HRDATA0..2, HRDATADEF          slave read data
//   HREADYOUT[2:0], HREADYOUTDEF   slave ready
//   HRESPS[2:0], HRESPDEF          slave response
//   HRDATA, HREADY, HRESP          routed data-phase response to the master
//   HANGIRQ                        one-cycle pulse when a hung slave is timed out
//
// Build option: define ARM_CM0IK_AHB_TIMEOUT_EN to include the hang-timeout FSM.
// Without it, HANGIRQ is tied low and a stalled slave stalls the bus indefinitely.
module cm0ik_ahb_dec_mux #(
    parameter logic [3:0] S0_REGION      = 4'h0,
    parameter logic [3:0] S1_REGION      = 4'h2,
    parameter logic [3:0] S2_REGION      = 4'h4,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic [2:0]  HSEL,
    output logic        HSELDEF,
    input  logic [31:0] HRDATA0,
    input  logic [31:0] HRDATA1,
    input  logic [31:0] HRDATA2,
    input  logic [31:0] HRDATADEF,
    input  logic [2:0]  HREADYOUT,
    input  logic        HREADYOUTDEF,
    input  logic [2:0]  HRESPS,
    input  logic        HRESPDEF,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic        HANGIRQ
);

    typedef enum logic [2:0] {
        SLOT_NONE = 3'd0,
        SLOT_S0   = 3'd1,
        SLOT_S1   = 3'd2,
        SLOT_S2   = 3'd3,
        SLOT_DEF  = 3'd4
    } slot_e;

    slot_e       slot_q, slot_d, dec_slot;
    logic [31:0] route_rdata;
    logic        route_ready;
    logic        route_resp;

    // Only the region nibble and the NONSEQ/SEQ bit take part in decode.
    logic unused_ok;
    assign unused_ok = ^{HADDR[27:0], HTRANS[0]};

    // Address decode; priority S0 > S1 > S2 keeps the select one-hot if regions overlap.
    always_comb begin
        HSEL     = 3'b000;
        HSELDEF  = 1'b0;
        dec_slot = SLOT_DEF;
        if (HADDR[31:28] == S0_REGION) begin
            HSEL[0]  = 1'b1;
            dec_slot = SLOT_S0;
        end else if (HADDR[31:28] == S1_REGION) begin
            HSEL[1]  = 1'b1;
            dec_slot = SLOT_S1;
        end else if (HADDR[31:28] == S2_REGION) begin
            HSEL[2]  = 1'b1;
            dec_slot = SLOT_S2;
        end else begin
            HSELDEF  = 1'b1;
        end
    end

    // Data-phase slot advances only when the bus is ready.
    always_comb begin
        slot_d = slot_q;
        if (HREADY) begin
            slot_d = HTRANS[1] ? dec_slot : SLOT_NONE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            slot_q <= SLOT_NONE;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Response mux for the slave that owns the current data phase.
    always_comb begin
        route_rdata = 32'h0;
        route_ready = 1'b1;
        route_resp  = 1'b0;
        case (slot_q)
            SLOT_S0: begin
                route_rdata = HRDATA0;
                route_ready = HREADYOUT[0];
                route_resp  = HRESPS[0];
            end
            SLOT_S1: begin
                route_rdata = HRDATA1;
                route_ready = HREADYOUT[1];
                route_resp  = HRESPS[1];
            end
            SLOT_S2: begin
                route_rdata = HRDATA2;
                route_ready = HREADYOUT[2];
                route_resp  = HRESPS[2];
            end
            SLOT_DEF: begin
                route_rdata = HRDATADEF;
                route_ready = HREADYOUTDEF;
                route_resp  = HRESPDEF;
            end
            default: ;
        endcase
    end

`ifdef ARM_CM0IK_AHB_TIMEOUT_EN
    typedef enum logic [1:0] {
        TO_IDLE  = 2'd0,
        TO_COUNT = 2'd1,
        TO_ERR1  = 2'd2,
        TO_ERR2  = 2'd3
    } to_state_e;

    // The detecting IDLE cycle counts as the first wait, so the limit is reached
    // after exactly TIMEOUT_CYCLES wait cycles seen by the master.
    localparam logic [7:0] CNT_LIMIT = TIMEOUT_CYCLES - 8'd1;

    to_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hangirq_q, hangirq_d;
    logic       stall_c;

    assign stall_c = (slot_q != SLOT_NONE) && !route_ready;

    // Timeout state register.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= TO_IDLE;
            cnt_q     <= 8'd0;
            hangirq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hangirq_q <= hangirq_d;
        end
    end

    // Timeout next-state; a slave going ready at the limit wins over the error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            TO_IDLE, TO_COUNT: begin
                if (stall_c) begin
                    if (cnt_q == CNT_LIMIT) begin
                        state_d = TO_ERR1;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = TO_COUNT;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = TO_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            TO_ERR1: state_d = TO_ERR2;
            TO_ERR2: state_d = TO_IDLE;
            default: state_d = TO_IDLE;
        endcase
        hangirq_d = (state_d == TO_ERR1);
    end

    // Master-facing outputs; the two ERROR cycles override the hung slave.
    always_comb begin
        HRDATA = route_rdata;
        HREADY = route_ready;
        HRESP  = route_resp;
        case (state_q)
            TO_ERR1: begin
                HRDATA = 32'h0;
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            TO_ERR2: begin
                HRDATA = 32'h0;
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
            default: ;
        endcase
    end

    assign HANGIRQ = hangirq_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;

    // Master-facing outputs come straight from the routed slave.
    always_comb begin
        HRDATA = route_rdata;
        HREADY = route_ready;
        HRESP  = route_resp;
    end

    assign HANGIRQ = 1'b0;
`endif

endmodule
